// File: rtl/rssb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rssb_pkg
// Purpose  : Shared widths, FSM encodings and the result FIFO entry type.
// Revision : 1.0
// ============================================================================
package rssb_pkg;

   localparam int c_bw = 1;
   localparam int c_ww = 8;
   localparam int c_fd = 4;
   localparam int c_cw = $clog2(c_ww + 1);

   typedef logic [1:0] state_t;
   localparam state_t c_st_run   = 2'd0;
   localparam state_t c_st_flush = 2'd1;
   localparam state_t c_st_done  = 2'd2;

   typedef struct packed {
      logic            last;
      logic [c_cw-1:0] cnt;
      logic [c_ww-1:0] data;
   } res_entry_t;

endpackage
`default_nettype wire

// File: rtl/rssb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rssb_sync_fifo
// Purpose  : Show-ahead synchronous FIFO; a push into a full FIFO is accepted
//            when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module rssb_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_pone = (AW+1)'(1);

   logic [AW:0]      r_wp;
   logic [AW:0]      r_rp;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push_ok;
   logic             w_pop_ok;

   // Extra wrap bit distinguishes full from empty when the indices match.
   assign o_empty   = (r_wp == r_rp);
   assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_head    = r_mem[r_rp[AW-1:0]];

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push_ok) r_wp <= r_wp + c_pone;
         if (w_pop_ok)  r_rp <= r_rp + c_pone;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wp[AW-1:0]] <= i_push_data;
   end

endmodule
`default_nettype wire

// File: rtl/rssb_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : rssb_result_packer
// Purpose  : Packs RSSB result beats LSB-first into words, queues them and
//            flushes a final tagged entry when the CPU halts.
// Revision : 1.0
// ============================================================================
module rssb_result_packer
   import rssb_pkg::*;
#(
   parameter  int BW = c_bw,
   parameter  int WW = c_ww,
   parameter  int FD = c_fd,
   localparam int CW = $clog2(WW + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [BW-1:0] in_data,
   input  logic          in_halt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WW-1:0] out_data,
   output logic [CW-1:0] out_cnt,
   output logic          out_last,
   output logic          overflow,
   output logic          done
);

   localparam int NB  = WW / BW;
   localparam int BCW = $clog2(NB + 1);
   localparam logic [BCW-1:0] c_bone = BCW'(1);
   localparam logic [BCW-1:0] c_blast = BCW'(NB - 1);

   state_t         r_state;
   logic [BCW-1:0] r_bcnt;
   logic [WW-1:0]  r_shift;
   logic           r_overflow;
   logic           r_last_dropped;

   logic           w_run;
   logic           w_acc;
   logic           w_halt;
   logic           w_complete;
   logic           w_push;
   logic           w_pop;
   logic           w_drop;
   logic           w_full;
   logic           w_empty;
   logic [WW-1:0]  w_beat;
   logic [WW-1:0]  w_merged;
   logic [BCW-1:0] w_nbcnt;
   res_entry_t     w_push_entry;
   res_entry_t     w_head;

   assign w_run      = (r_state == c_st_run);
   assign w_acc      = w_run && in_valid;
   assign w_halt     = w_run && in_halt;
   assign w_complete = w_acc && (r_bcnt == c_blast);

   always_comb begin
      w_beat          = '0;
      w_beat[BW-1:0]  = in_data;
      w_merged        = r_shift;
      w_nbcnt         = r_bcnt;
      if (w_acc) begin
         w_merged = r_shift | (w_beat << (r_bcnt * BW));
         w_nbcnt  = w_complete ? '0 : r_bcnt + c_bone;
      end
   end

   // With nothing held the shift register is already zero, so the halt
   // marker falls out of the same path as a partial word.
   always_comb begin
      w_push_entry      = '0;
      w_push_entry.last = w_halt;
      w_push_entry.data = w_merged;
      w_push_entry.cnt  = w_complete ? CW'(WW) : CW'(w_nbcnt * BW);
   end

   assign w_push = w_complete || w_halt;
   assign w_pop  = !w_empty && out_ready;
   assign w_drop = w_push && w_full && !w_pop;

   rssb_sync_fifo #(
      .WIDTH ($bits(res_entry_t)),
      .DEPTH (FD)
   ) u_fifo (
      .clk         (clk),
      .i_rst       (rst),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= c_st_run;
         r_bcnt         <= '0;
         r_shift        <= '0;
         r_overflow     <= 1'b0;
         r_last_dropped <= 1'b0;
      end else begin
         r_bcnt  <= w_halt ? '0 : w_nbcnt;
         r_shift <= (w_halt || w_complete) ? '0 : w_merged;
         if (w_drop) r_overflow <= 1'b1;
         case (r_state)
            c_st_run: begin
               if (w_halt) begin
                  r_state        <= c_st_flush;
                  r_last_dropped <= w_drop;
               end
            end
            c_st_flush: begin
               if ((w_pop && w_head.last) || (w_empty && r_last_dropped))
                  r_state <= c_st_done;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : w_head.data;
   assign out_cnt   = w_empty ? '0 : w_head.cnt;
   assign out_last  = !w_empty && w_head.last;
   assign overflow  = r_overflow;
   assign done      = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_rssb_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rssb_result_packer
// Purpose  : Directed scoreboard bench for the RSSB result packer.
// Revision : 1.0
// ============================================================================
module tb_rssb_result_packer;

   typedef struct {
      logic [7:0] data;
      logic [3:0] cnt;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [0:0] in_data = 1'b0;
   logic       in_halt = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [3:0] out_cnt;
   logic       out_last;
   logic       overflow;
   logic       done;

   int   checks = 0;
   int   failures = 0;
   int   pops = 0;
   exp_t sb[$];

   logic [7:0] m_shift = 8'h00;
   int         m_n = 0;
   bit         m_live = 1'b1;

   always #5 clk = ~clk;

   rssb_result_packer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_halt   (in_halt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_cnt   (out_cnt),
      .out_last  (out_last),
      .overflow  (overflow),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: LSB-first packing plus halt flush, fed in lock-step with the DUT.
   task automatic drive(input logic v, input logic b, input logic h);
      exp_t e;
      bit   completed;
      completed = 1'b0;
      in_valid  = v;
      in_data   = b;
      in_halt   = h;
      if (v && m_live) begin
         m_shift[m_n] = b;
         m_n++;
         if (m_n == 8) begin
            e.data = m_shift; e.cnt = 4'd8; e.last = h;
            sb.push_back(e);
            m_shift = 8'h00; m_n = 0; completed = 1'b1;
         end
      end
      if (h && m_live && !completed) begin
         e.data = m_shift; e.cnt = 4'(m_n); e.last = 1'b1;
         sb.push_back(e);
         m_shift = 8'h00; m_n = 0;
      end
      if (h) m_live = 1'b0;
      tick();
      in_valid = 1'b0;
      in_data  = 1'b0;
      in_halt  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; in_halt = 1'b0; in_data = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      sb.delete();
      m_shift = 8'h00; m_n = 0; m_live = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         exp_t e;
         pops++;
         check("pop_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pop_data", 32'(out_data), 32'(e.data));
            check("pop_cnt",  32'(out_cnt),  32'(e.cnt));
            check("pop_last", 32'(out_last), 32'(e.last));
         end
      end
   end

   initial begin
      logic [7:0] pat;
      int         p0;

      #2 rst = 1'b0;
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_cnt",   32'(out_cnt),   32'd0);
      check("rst_out_last",  32'(out_last),  32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      check("rst_done",      32'(done),      32'd0);
      tick();
      rst = 1'b1;

      // Single full word, valid one cycle after the completing beat.
      out_ready = 1'b1;
      pat = 8'h4D;
      for (int i = 0; i < 7; i++) drive(1'b1, pat[i], 1'b0);
      check("t1_not_early", 32'(out_valid), 32'd0);
      drive(1'b1, pat[7], 1'b0);
      check("t1_valid_after_8", 32'(out_valid), 32'd1);
      check("t1_overflow", 32'(overflow), 32'd0);
      tick();
      check("t1_drained", 32'(out_valid), 32'd0);

      // Partial word flushed by halt, then capture ends.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      check("t2_last_valid", 32'(out_valid), 32'd1);
      check("t2_not_done_yet", 32'(done), 32'd0);
      tick();
      check("t2_done", 32'(done), 32'd1);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      check("t2_ignored_valid", 32'(out_valid), 32'd0);
      check("t2_still_done", 32'(done), 32'd1);

      // Five words into a four-deep FIFO with the sink stalled.
      do_reset();
      for (int i = 0; i < 32; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check("t3_no_ovf_at_4", 32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_sb_words", 32'(sb.size()), 32'd5);
      void'(sb.pop_back());
      out_ready = 1'b1;
      for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
      check("t3_all_popped", 32'(sb.size()), 32'd0);
      check("t3_empty", 32'(out_valid), 32'd0);

      // Word completes while full and the head pops in the same cycle.
      do_reset();
      for (int i = 0; i < 39; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      out_ready = 1'b1;
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      out_ready = 1'b0;
      check("t4_overflow", 32'(overflow), 32'd0);
      p0 = pops;
      out_ready = 1'b1;
      for (int i = 0; i < 10 && out_valid; i++) tick();
      check("t4_occupancy", 32'(pops - p0), 32'd4);
      check("t4_drained", 32'(out_valid), 32'd0);

      // Halt with nothing held gives an empty marker.
      do_reset();
      out_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b1);
      check("t5_marker_valid", 32'(out_valid), 32'd1);
      tick();
      check("t5_marker_done", 32'(done), 32'd1);

      // Halt on the completing beat: one full last word, no extra marker.
      do_reset();
      out_ready = 1'b1;
      pat = 8'hB6;
      for (int i = 0; i < 7; i++) drive(1'b1, pat[i], 1'b0);
      drive(1'b1, pat[7], 1'b1);
      check("t5_full_last_valid", 32'(out_valid), 32'd1);
      tick();
      check("t5_no_marker", 32'(out_valid), 32'd0);
      check("t5_full_done", 32'(done), 32'd1);
      check("t5_sb_empty", 32'(sb.size()), 32'd0);

      // Asynchronous reset mid-word with an entry queued.
      do_reset();
      for (int i = 0; i < 8; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
      check("t6_queued", 32'(out_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("t6_async_valid", 32'(out_valid), 32'd0);
      check("t6_async_ovf",   32'(overflow),  32'd0);
      check("t6_async_done",  32'(done),      32'd0);
      sb.delete();
      m_shift = 8'h00; m_n = 0; m_live = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      out_ready = 1'b1;
      pat = 8'h02;
      for (int i = 0; i < 8; i++) drive(1'b1, pat[i], 1'b0);
      check("t6_fresh_valid", 32'(out_valid), 32'd1);
      tick();
      tick();
      check("t6_sb_empty", 32'(sb.size()), 32'd0);
      check("t6_drained", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
